// File: rtl/alu_pkg.sv
// Shared ALU control codes and MIPS funct codes for the execute stage.
package alu_pkg;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLTU = 4'b1000;
  localparam logic [3:0] CTL_NOR  = 4'b1100;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/add32.sv
// Plain combinational WIDTH-bit adder, wraps modulo 2^WIDTH.
// Latency 0; no flow control.
module add32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, MIPS ALU and PC adders, one register stage.
// Latency 1 cycle; outputs update every cycle, no handshake or back-pressure.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] branch_offset,
  output logic             out_valid,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_res,
  output logic             zero,
  output logic             ovf,
  output logic             cout,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target
);

  logic [3:0]       ctl;
  logic [WIDTH-1:0] res;
  logic             ovf_c;
  logic             cout_c;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] pc4_c;
  logic [WIDTH-1:0] bt_c;

  always_comb begin
    ctl = CTL_ADD;
    case (alu_op)
      FN_ADD, FN_ADDU: ctl = CTL_ADD;
      FN_SUB, FN_SUBU: ctl = CTL_SUB;
      FN_AND:          ctl = CTL_AND;
      FN_OR:           ctl = CTL_OR;
      FN_XOR:          ctl = CTL_XOR;
      FN_NOR:          ctl = CTL_NOR;
      FN_SLT:          ctl = CTL_SLT;
      FN_SLTU:         ctl = CTL_SLTU;
      default:         ctl = CTL_ADD;
    endcase
  end

  // Carry-out of the subtract path is the inverted borrow.
  assign add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res    = '0;
    ovf_c  = 1'b0;
    cout_c = 1'b0;
    case (ctl)
      CTL_ADD: begin
        res    = add_w[WIDTH-1:0];
        cout_c = add_w[WIDTH];
        ovf_c  = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      CTL_SUB: begin
        res    = sub_w[WIDTH-1:0];
        cout_c = sub_w[WIDTH];
        ovf_c  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      CTL_AND:  res = a & b;
      CTL_OR:   res = a | b;
      CTL_XOR:  res = a ^ b;
      CTL_NOR:  res = ~(a | b);
      // Direct comparisons stay correct when a-b would overflow.
      CTL_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTL_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  res = '0;
    endcase
  end

  add32 #(.WIDTH(WIDTH)) u_pc_step (
    .a   (pc),
    .b   (WIDTH'(PC_STEP)),
    .sum (pc4_c)
  );

  add32 #(.WIDTH(WIDTH)) u_branch (
    .a   (pc4_c),
    .b   (branch_offset),
    .sum (bt_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      alu_ctl       <= '0;
      alu_res       <= '0;
      zero          <= 1'b0;
      ovf           <= 1'b0;
      cout          <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      out_valid     <= in_valid;
      alu_ctl       <= ctl;
      alu_res       <= res;
      zero          <= (res == '0);
      ovf           <= ovf_c;
      cout          <= cout_c;
      pc_plus4      <= pc4_c;
      branch_target <= bt_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  alu_op;
  logic [31:0] a, b, pc, branch_offset;
  logic        cin;
  logic        out_valid, zero, ovf, cout;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_res, pc_plus4, branch_target;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .PC_STEP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .alu_op        (alu_op),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .pc            (pc),
    .branch_offset (branch_offset),
    .out_valid     (out_valid),
    .alu_ctl       (alu_ctl),
    .alu_res       (alu_res),
    .zero          (zero),
    .ovf           (ovf),
    .cout          (cout),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  typedef struct {
    logic        v;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic        ovf;
    logic        co;
    logic [31:0] pc4;
    logic [31:0] bt;
  } exp_t;

  exp_t expv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Overflow means the exact signed result does not survive truncation to 32 bits.
  function automatic exp_t model(input logic rn, input logic v, input logic [5:0] op,
                                 input logic [31:0] x, input logic [31:0] y, input logic ci,
                                 input logic [31:0] p, input logic [31:0] off);
    exp_t   e;
    longint s;
    longint u;
    e = '{v: 1'b0, ctl: 4'd0, res: 32'd0, z: 1'b0, ovf: 1'b0, co: 1'b0, pc4: 32'd0, bt: 32'd0};
    if (!rn) return e;
    e.v = v;
    case (op)
      6'h22, 6'h23: e.ctl = 4'b0110;
      6'h24:        e.ctl = 4'b0000;
      6'h25:        e.ctl = 4'b0001;
      6'h26:        e.ctl = 4'b0011;
      6'h27:        e.ctl = 4'b1100;
      6'h2A:        e.ctl = 4'b0111;
      6'h2B:        e.ctl = 4'b1000;
      default:      e.ctl = 4'b0010;
    endcase
    case (op)
      6'h22, 6'h23: begin
        e.res = x - y;
        e.co  = (x >= y);
        s     = longint'($signed(x)) - longint'($signed(y));
        e.ovf = (s != longint'($signed(s[31:0])));
      end
      6'h24: e.res = x & y;
      6'h25: e.res = x | y;
      6'h26: e.res = x ^ y;
      6'h27: e.res = ~(x | y);
      6'h2A: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6'h2B: e.res = (x < y) ? 32'd1 : 32'd0;
      default: begin
        u     = longint'(x) + longint'(y) + longint'(ci);
        e.res = u[31:0];
        e.co  = u[32];
        s     = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        e.ovf = (s != longint'($signed(s[31:0])));
      end
    endcase
    e.z   = (e.res == 32'd0);
    e.pc4 = p + 32'd4;
    e.bt  = p + 32'd4 + off;
    return e;
  endfunction

  always @(posedge clk) begin
    expv    = model(reset, in_valid, alu_op, a, b, cin, pc, branch_offset);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", 32'(out_valid), 32'(expv.v));
      chk("m_alu_ctl",   32'(alu_ctl),   32'(expv.ctl));
      chk("m_alu_res",   alu_res,        expv.res);
      chk("m_zero",      32'(zero),      32'(expv.z));
      chk("m_ovf",       32'(ovf),       32'(expv.ovf));
      chk("m_cout",      32'(cout),      32'(expv.co));
      chk("m_pc_plus4",  pc_plus4,       expv.pc4);
      chk("m_branch",    branch_target,  expv.bt);
    end
  end

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic apply(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic [31:0] p, input logic [31:0] off);
    reset = 1'b1; in_valid = 1'b1; alu_op = op; a = x; b = y; cin = ci;
    pc = p; branch_offset = off;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] codes [10];
    codes = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    reset = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      alu_op = 6'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
      pc = $urandom; branch_offset = $urandom;
      @(negedge clk);
    end
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_res",   alu_res,        32'd0);
    chk("rst_alu_ctl",   32'(alu_ctl),   32'd0);
    chk("rst_flags",     {29'd0, zero, ovf, cout}, 32'd0);
    chk("rst_pc",        pc_plus4 | branch_target, 32'd0);

    apply(6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h0040_0000, 32'hFFFF_FFF8);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_res",   alu_res, 32'h8000_0000);
    chk("add_flags", {28'd0, alu_ctl}, 32'h2);
    chk("add_ovf_cout_zero", {29'd0, ovf, cout, zero}, 32'b100);
    chk("pc_plus4",  pc_plus4, 32'h0040_0004);
    chk("pc_branch", branch_target, 32'h003F_FFFC);

    apply(6'h22, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 32'd0);
    chk("sub_eq_res", alu_res, 32'd0);
    chk("sub_eq_zco", {29'd0, zero, cout, ovf}, 32'b110);
    chk("pc_wrap",    pc_plus4, 32'd0);

    apply(6'h22, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 32'd0);
    chk("sub_ovf_res", alu_res, 32'h7FFF_FFFF);
    chk("sub_ovf",     32'(ovf), 32'd1);

    apply(6'h2A, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
    chk("slt_neg", alu_res, 32'd1);
    apply(6'h2B, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
    chk("sltu_big", alu_res, 32'd0);
    apply(6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0, 32'd0);
    chk("slt_ovfcase", alu_res, 32'd1);

    apply(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 32'd0);
    chk("and", alu_res, 32'hF000_F000);
    apply(6'h27, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("nor", alu_res, 32'hFFFF_FFFF);
    apply(6'h26, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
    chk("xor", alu_res, 32'h5555_5555);
    apply(6'h3F, 32'd2, 32'd3, 1'b1, 32'd0, 32'd0);
    chk("dflt_res", alu_res, 32'd6);
    chk("dflt_ctl", 32'(alu_ctl), 32'h2);

    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 39) != 0);
      in_valid = 1'($urandom);
      alu_op   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : codes[$urandom_range(0, 9)];
      a        = rnd_word();
      b        = ($urandom_range(0, 5) == 0) ? a : rnd_word();
      cin      = 1'($urandom);
      pc       = rnd_word();
      branch_offset = rnd_word();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage arithmetic block of the single-cycle MIPS datapath. Combines three functions:
  - the ALU-control decoder, mapping a 6-bit ALU op to a 4-bit ALU control code;
  - the 32-bit MIPS ALU;
  - the two PC adders: PC+4, and branch target = PC+4 + offset.
- All results are registered once, on the rising clock edge, with a valid flag alongside.

Parameters:
- WIDTH, 32, datapath width for operands, results and PC.
- PC_STEP, 4, constant added to pc by the sequential-PC adder.

Ports:
- clk  in  1  system clock; rising-edge active.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  inputs valid this cycle.
- alu_op  in  6  ALU operation, funct-style code from the control unit.
- a  in  WIDTH  operand A (rs data).
- b  in  WIDTH  operand B (rt data or sign-extended immediate).
- cin  in  1  carry-in; used by ADD only.
- pc  in  WIDTH  current instruction address.
- branch_offset  in  WIDTH  sign-extended immediate, already shifted left by 2.
- out_valid  out  1  registered in_valid.
- alu_ctl  out  4  registered decoded control code.
- alu_res  out  WIDTH  registered ALU result.
- zero  out  1  registered flag: alu_res == 0.
- ovf  out  1  registered signed-overflow flag.
- cout  out  1  registered carry-out.
- pc_plus4  out  WIDTH  registered pc + PC_STEP.
- branch_target  out  WIDTH  registered pc + PC_STEP + branch_offset.

Behaviour:
- Reset: while reset==0 at a rising edge, every output register clears to 0, including out_valid. Reset overrides in_valid, and an operation in flight is discarded.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Output registers update every cycle, whatever the value of in_valid; out_valid simply follows in_valid. There is no handshake and no back-pressure.
- alu_op to alu_ctl decode:
  - 0x20 or 0x21 (add/addu) -> 0010 ADD
  - 0x22 or 0x23 (sub/subu) -> 0110 SUB
  - 0x24 -> 0000 AND
  - 0x25 -> 0001 OR
  - 0x26 -> 0011 XOR
  - 0x27 -> 1100 NOR
  - 0x2A -> 0111 SLT
  - 0x2B -> 1000 SLTU
  - any other code -> 0010 ADD
- ADD: {cout, res} = a + b + cin, computed WIDTH+1 bits wide. ovf = (a[31]==b[31]) && (res[31]!=a[31]).
- SUB: {cout, res} = a + ~b + 1; cin is ignored, and cout=1 means no borrow. ovf = (a[31]!=b[31]) && (res[31]!=a[31]).
- AND, OR, XOR, NOR: bitwise results. ovf=0, cout=0.
- SLT: res = {31'b0, signed(a) < signed(b)}. The comparison must be correct even when a-b overflows. ovf=0, cout=0.
- SLTU: res = {31'b0, a < b}, unsigned compare. ovf=0, cout=0.
- Any unused alu_ctl code inside the ALU: res=0, ovf=0, cout=0.
- zero = (res == 0) for every operation.
- PC adders: pc_plus4 = pc + PC_STEP and branch_target = pc_plus4 + branch_offset, both modulo 2^WIDTH. No carry or overflow outputs. Wrap-around is required, e.g. pc=0xFFFFFFFC gives pc_plus4=0.
- The ALU and both adders run in parallel every cycle, independent of alu_op.

Decomposition:
- Shared package alu_pkg holds:
  - the alu_ctl localparams: CTL_AND, CTL_OR, CTL_ADD, CTL_XOR, CTL_SUB, CTL_SLT, CTL_SLTU, CTL_NOR;
  - the funct-code constants 0x20–0x2B.
- One natural sub-module: add32, a WIDTH-bit combinational adder (sum = a + b). It is instantiated twice for the PC path.
- The decoder and the ALU stay as combinational always blocks in the top level, followed by one output register stage.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and random inputs for 2 edges. Required: all outputs 0. Release reset; the next edge shows valid results.
- Add overflow: alu_op=0x20, a=0x7FFFFFFF, b=1, cin=0. Required one edge later: alu_res=0x80000000, ovf=1, cout=0, zero=0, alu_ctl=0010.
- Sub equal / bne zero: alu_op=0x22, a=b=0x12345678. Required: alu_res=0, zero=1, cout=1, ovf=0. Then a=0x80000000, b=1 gives alu_res=0x7FFFFFFF, ovf=1.
- SLT vs SLTU: a=0xFFFFFFFF, b=1. With alu_op=0x2A, alu_res=1. With 0x2B, alu_res=0. With a=0x80000000, b=0x7FFFFFFF and 0x2A, alu_res=1 (overflow case).
- Logic and default decode:
  - AND, a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000
  - NOR, a=b=0 -> 0xFFFFFFFF
  - XOR, a=0xAAAAAAAA, b=0xFFFFFFFF -> 0x55555555
  - alu_op=0x3F, a=2, b=3, cin=1 -> ADD, alu_res=6
- PC adders: pc=0x00400000, branch_offset=0xFFFFFFF8 -> pc_plus4=0x00400004, branch_target=0x003FFFFC. pc=0xFFFFFFFC -> pc_plus4=0.
